// File: rtl/pmc_pkg.sv
// Shared types and constants for the PMC counter readout path.
package pmc_pkg;

    localparam int PMC_CNT_W   = 256;
    localparam int PMC_WORD_W  = 32;
    localparam int PMC_NUM_CNT = 4;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    localparam int CNT_STALL = 0;
    localparam int CNT_CPI   = 1;
    localparam int CNT_ARITH = 2;
    localparam int CNT_MEM   = 3;

    localparam logic [15:0] PMC_HDR_MAGIC = 16'h504D;

endpackage

// File: rtl/pmc_word_mux.sv
// Selects word k out of the flattened snapshot; counter 0 occupies the lowest bits,
// so word k sits at bit offset k*WORD_W. Out-of-range indices read as zero.
module pmc_word_mux
    import pmc_pkg::*;
#(
    parameter int CNT_W   = PMC_CNT_W,
    parameter int WORD_W  = PMC_WORD_W,
    parameter int NUM_CNT = PMC_NUM_CNT
) (
    input  logic [NUM_CNT*CNT_W-1:0] snap,
    input  logic [5:0]               idx,
    output logic [WORD_W-1:0]        word
);

    localparam int NUM_WORDS = NUM_CNT * CNT_W / WORD_W;

    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (idx == 6'(k)) begin
                word = snap[k*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/pmc_readout.sv
// Snapshots the four PMC counters on req and streams them out word by word.
// Optional header word per dump is enabled by defining PMC_READOUT_HEADER_EN.
module pmc_readout
    import pmc_pkg::*;
#(
    parameter int CNT_W   = PMC_CNT_W,
    parameter int WORD_W  = PMC_WORD_W,
    parameter int NUM_CNT = PMC_NUM_CNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  stall_count,
    input  logic [CNT_W-1:0]  cycles_per_instruction_q78,
    input  logic [CNT_W-1:0]  arith_count,
    input  logic [CNT_W-1:0]  mem_access_count,
    input  logic              req,
    output logic              busy,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [5:0]        word_idx,
    output logic              word_last,
    output logic              done
);

    localparam int WPC     = CNT_W / WORD_W;
    localparam int PAYLOAD = NUM_CNT * WPC;
`ifdef PMC_READOUT_HEADER_EN
    localparam int TOTAL   = PAYLOAD + 1;
`else
    localparam int TOTAL   = PAYLOAD;
`endif
    localparam logic [5:0] LAST_IDX = 6'(TOTAL - 1);

    state_t                   state;
    logic [5:0]               idx;
    logic [NUM_CNT*CNT_W-1:0] snap;
    logic [5:0]               payload_idx;
    logic [WORD_W-1:0]        payload_word;
    logic [WORD_W-1:0]        word_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            snap  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        snap[CNT_STALL*CNT_W +: CNT_W] <= stall_count;
                        snap[CNT_CPI*CNT_W   +: CNT_W] <= cycles_per_instruction_q78;
                        snap[CNT_ARITH*CNT_W +: CNT_W] <= arith_count;
                        snap[CNT_MEM*CNT_W   +: CNT_W] <= mem_access_count;
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (word_ready) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= DONE;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PMC_READOUT_HEADER_EN
    logic [7:0] seq;

    // Sequence number advances once per completed dump, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq <= '0;
        end else if (state == DONE) begin
            seq <= seq + 8'd1;
        end
    end

    assign payload_idx = idx - 6'd1;
    assign word_sel    = (idx == 6'd0) ? {PMC_HDR_MAGIC, 8'(PAYLOAD), seq} : payload_word;
`else
    assign payload_idx = idx;
    assign word_sel    = payload_word;
`endif

    pmc_word_mux #(
        .CNT_W   (CNT_W),
        .WORD_W  (WORD_W),
        .NUM_CNT (NUM_CNT)
    ) u_word_mux (
        .snap (snap),
        .idx  (payload_idx),
        .word (payload_word)
    );

    // All outputs decode registered state only; word_ready never reaches word_valid.
    assign busy       = (state != IDLE);
    assign word_valid = (state == SEND);
    assign done       = (state == DONE);
    assign word_last  = (state == SEND) && (idx == LAST_IDX);
    assign word_idx   = idx;
    assign word_data  = word_valid ? word_sel : '0;

endmodule

// File: tb/tb_pmc_readout.sv
// Self-checking bench for pmc_readout: behavioural dump model plus literal pins.
module tb_pmc_readout;

`ifdef PMC_READOUT_HEADER_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif
    localparam int TOTAL = 32 + H;
    localparam int LAST  = TOTAL - 1;

    logic         clk = 0;
    logic         reset = 1;
    logic [255:0] stall_count = '0, cpi = '0, arith_count = '0, mem_count = '0;
    logic         req = 0;
    logic         busy, word_valid, word_last, done;
    logic [31:0]  word_data;
    logic         word_ready = 1;
    logic [5:0]   word_idx;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    pmc_readout dut (
        .clk                        (clk),
        .reset                      (reset),
        .stall_count                (stall_count),
        .cycles_per_instruction_q78 (cpi),
        .arith_count                (arith_count),
        .mem_access_count           (mem_count),
        .req                        (req),
        .busy                       (busy),
        .word_data                  (word_data),
        .word_valid                 (word_valid),
        .word_ready                 (word_ready),
        .word_idx                   (word_idx),
        .word_last                  (word_last),
        .done                       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Word k of a dump, straight from the word-order rules.
    function automatic logic [31:0] word_of(input int k, input logic [255:0] s, input logic [255:0] c,
                                            input logic [255:0] a, input logic [255:0] m, input int seq);
        logic [255:0] cnt;
        int j;
        if (H == 1 && k == 0) return {16'h504D, 8'd32, 8'(seq)};
        j = k - H;
        case (j / 8)
            0: cnt = s;
            1: cnt = c;
            2: cnt = a;
            default: cnt = m;
        endcase
        return cnt[(j % 8)*32 +: 32];
    endfunction

    // Behavioural model: phase 0 idle, 1 streaming word m_k, 2 done pulse.
    int          m_phase = 0, m_k = 0, m_seq = 0;
    bit          m_hold = 0;
    logic [31:0] m_words [TOTAL];

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_k     <= 0;
            m_seq   <= 0;
            m_hold  <= 0;
        end else begin
            m_hold <= (m_phase == 1) && !word_ready;
            case (m_phase)
                0: if (req) begin
                    for (int k = 0; k < TOTAL; k++)
                        m_words[k] <= word_of(k, stall_count, cpi, arith_count, mem_count, m_seq);
                    m_phase <= 1;
                    m_k     <= 0;
                end
                1: if (word_ready) begin
                    if (m_k == LAST) m_phase <= 2;
                    else m_k <= m_k + 1;
                end
                default: begin
                    m_phase <= 0;
                    m_seq   <= (m_seq + 1) % 256;
                end
            endcase
        end
    end

    logic [31:0] last_data;
    logic [5:0]  last_idx;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, 32'(m_phase != 0));
            chk("word_valid", word_valid, 32'(m_phase == 1));
            chk("done", done, 32'(m_phase == 2));
            if (m_phase == 1) begin
                chk("word_data", word_data, m_words[m_k]);
                chk("word_idx", 32'(word_idx), 32'(m_k));
                chk("word_last", word_last, 32'(m_k == LAST));
                if (m_hold) begin
                    chk("hold_data", word_data, last_data);
                    chk("hold_idx", 32'(word_idx), 32'(last_idx));
                end
            end
            last_data = word_data;
            last_idx  = word_idx;
        end
    end

    task automatic pulse_req();
        @(negedge clk) req = 1;
        @(negedge clk) req = 0;
    endtask

    // Must be called at a negedge; looks at the current cycle first.
    task automatic pin(input int k, input logic [31:0] exp, input string name);
        bit seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (word_valid && word_idx == 6'(k)) begin
                seen = 1;
                chk(name, word_data, exp);
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for idx %0d", name, k);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s timeout waiting for done", name);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        // Reset held with req asserted: nothing starts.
        req = 1;
        @(posedge clk);
        chk_en = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_valid", word_valid, 0);
            chk("rst_done", done, 0);
            chk("rst_idx", 32'(word_idx), 0);
            chk("rst_data", word_data, 0);
        end
        req = 0;
        reset = 0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        // Basic dump with literal expectations.
        stall_count = 256'h10000000_20000000_30000000_40000000_50000000_60000000_70000000_DEADBEEF;
        cpi         = 256'h0000_0180;
        arith_count = 256'd1000;
        mem_count   = 256'hFFFF_FFFF_0000_0001;
        word_ready  = 1;
        pulse_req();
        pin(H + 0, 32'hDEADBEEF, "basic_w0");
        pin(H + 7, 32'h10000000, "basic_w7");
        pin(H + 8, 32'h0000_0180, "basic_w8");
        pin(H + 16, 32'd1000, "basic_w16");
        pin(H + 24, 32'h0000_0001, "basic_w24");
        pin(H + 25, 32'hFFFF_FFFF, "basic_w25");
        pin(LAST, 32'h0, "basic_wlast");
        chk("basic_last_flag", word_last, 1);
        @(negedge clk);
        chk("basic_done", done, 1);
        @(negedge clk);
        chk("basic_done_one", done, 0);

        // Backpressure: alternating ready plus a 5-cycle stall at idx 12.
        begin
            int stretch = 0;
            bit stretched = 0;
            word_ready = 0;
            pulse_req();
            for (int c = 0; c < 400 && !done; c++) begin
                if (!stretched && word_valid && word_idx == 6'(H + 12)) begin
                    stretched = 1;
                    stretch = 5;
                end
                if (stretch > 0) begin
                    word_ready = 0;
                    stretch--;
                end else begin
                    word_ready = ~word_ready;
                end
                @(negedge clk);
            end
            wait_done("bp");
            word_ready = 1;
        end

        // Snapshot isolation.
        arith_count = 256'd1000;
        pulse_req();
        pin(H + 3, word_of(H + 3, stall_count, cpi, 256'd1000, mem_count, 0), "iso_w3");
        arith_count = 256'd7;
        pin(H + 16, 32'd1000, "iso_w16");
        wait_done("iso");

        // req during SEND and DONE ignored; reset mid-dump.
        pulse_req();
        pin(H + 5, word_of(H + 5, stall_count, cpi, arith_count, mem_count, 0), "ign_w5");
        req = 1;
        @(negedge clk) req = 0;
        wait_done("ign");
        req = 1;
        @(negedge clk) req = 0;
        repeat (2) @(negedge clk);
        chk("ign_no_restart", busy, 0);
        pulse_req();
        pin(H + 10, word_of(H + 10, stall_count, cpi, arith_count, mem_count, 0), "rst_w10");
        reset = 1;
        @(negedge clk);
        chk("midrst_valid", word_valid, 0);
        chk("midrst_busy", busy, 0);
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_done", done, 0);
            @(negedge clk);
        end
        stall_count = 256'h55;
        pulse_req();
        pin(H + 0, word_of(H + 0, 256'h55, cpi, arith_count, mem_count, 0), "restart_w0");
        wait_done("restart");

        // Back-to-back dumps after a fresh reset.
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        stall_count = 256'hABCD_1234;
        pulse_req();
`ifdef PMC_READOUT_HEADER_EN
        pin(0, 32'h504D_2000, "hdr_first");
        pin(1, 32'hABCD_1234, "hdr_stall_w1");
`else
        pin(0, 32'hABCD_1234, "b2b_first_w0");
`endif
        pin(LAST, word_of(LAST, stall_count, cpi, arith_count, mem_count, 0), "b2b_wlast");
        chk("b2b_last_flag", word_last, 1);
        wait_done("b2b1");
        req = 1;
        repeat (2) @(negedge clk);
        req = 0;
`ifdef PMC_READOUT_HEADER_EN
        pin(0, 32'h504D_2001, "hdr_second");
`else
        pin(0, 32'hABCD_1234, "b2b_second_w0");
`endif
        wait_done("b2b2");

        // Randomized traffic: noisy req, random ready, drifting counters.
        begin
            int dumps = 0;
            for (int c = 0; c < 3000 && dumps < 5; c++) begin
                @(negedge clk);
                if (done) dumps++;
                word_ready = ($urandom_range(0, 99) < 60);
                req = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    stall_count = rnd256();
                    cpi         = rnd256();
                    arith_count = rnd256();
                    mem_count   = rnd256();
                end
            end
            req = 0;
            checks++;
            if (dumps < 5) begin
                failures++;
                $display("FAIL random_dumps actual=%0d required=5", dumps);
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
